verify_arbiter: RTL and testbench

VERIFY_ARBITER -- requirements
Module: verify_arbiter

---
 rtl/verify_arbiter_pkg.sv | 21 ++
 rtl/verify_arbiter_pearson_hash8.sv | 41 ++++
 rtl/verify_arbiter.sv | 139 +++++++++++++
 tb/tb_verify_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/verify_arbiter_pkg.sv
// Shared definitions for the key-verification arbiter.
//   NUM_REQ_DEF      default number of requesters
//   HASH_CYCLES_DEF  default hash-engine latency after its reset is released
//   REJECT_KEY       public key value that is rejected without hashing
//   TABLE_W          width of the random table handed to the hash engine
//   state_e          arbiter FSM state encoding
package verify_arbiter_pkg;

   localparam int         NUM_REQ_DEF     = 4;
   localparam int         HASH_CYCLES_DEF = 8;
   localparam logic [7:0] REJECT_KEY      = 8'h00;
   localparam int         TABLE_W         = 258;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HASH  = 2'd1,
      ST_CHECK = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/verify_arbiter_pearson_hash8.sv
// Iterative 8-bit Pearson-style hash.
// Each round looks up 3 bits of random_table at bit offset (h ^ key) and
// shifts them into h: h <= {h[4:0], table[idx+2:idx]}. After ROUNDS rounds
// the engine stops updating and hash holds the final value.
// Ports:
//   clock         rising-edge clock
//   reset_n       synchronous active-low reset (clears h and the round count)
//   key           8-bit key being hashed
//   random_table  258-bit lookup table (offsets 0..255, 3-bit window)
//   hash          current hash value, valid once ROUNDS rounds have run
module pearson_hash8
   import verify_arbiter_pkg::*;
#(
   parameter int ROUNDS = HASH_CYCLES_DEF
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [7:0]         key,
   input  logic [TABLE_W-1:0] random_table,
   output logic [7:0]         hash
);

   logic [7:0] h_q;
   logic [4:0] round_q;
   logic [8:0] idx;

   assign idx = {1'b0, h_q ^ key};

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         h_q     <= '0;
         round_q <= '0;
      end else if (round_q < 5'(ROUNDS)) begin
         h_q     <= {h_q[4:0], random_table[idx +: 3]};
         round_q <= round_q + 5'd1;
      end
   end

   assign hash = h_q;

endmodule

// File: rtl/verify_arbiter.sv
// Round-robin arbiter sharing one Pearson hash engine among NUM_REQ
// requesters. A granted requester's keys are latched, the input key is
// hashed, and the hash is compared against the latched public key.
// Ports:
//   clock, reset_n  clock and synchronous active-low reset
//   req             per-requester level request
//   public_keys     packed 8-bit public keys, requester i at [8i+7:8i]
//   input_keys      packed 8-bit candidate keys, same packing
//   random_table    hash lookup table, passed to the engine unchanged
//   grant           one-hot, grant cycle through done cycle
//   done            one-cycle pulse to the granted requester
//   correct         verification result, valid with done
//   busy            high whenever the FSM is not idle
//
// state   | meaning
// IDLE    | waiting; picks next requester at/after round-robin pointer
// HASH    | hash engine running, down-counter times HASH_CYCLES cycles
// CHECK   | compare hash with latched public key into result flop
// RESP    | done/correct pulse, advance pointer
module verify_arbiter
   import verify_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = NUM_REQ_DEF,
   parameter int HASH_CYCLES = HASH_CYCLES_DEF
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] public_keys,
   input  logic [8*NUM_REQ-1:0] input_keys,
   input  logic [TABLE_W-1:0]   random_table,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   done,
   output logic                 correct,
   output logic                 busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   gnt_idx_q, rr_ptr_q;
   logic [7:0]         pub_key_q, in_key_q;
   logic [3:0]         cnt_q;
   logic               result_q;

   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx, cand;
   logic [7:0]         pick_pub, pick_in;
   logic               hash_rst_n;
   logic [7:0]         hash_val;

   // First requesting index at or after the pointer, wrapping around.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = IDX_W'((int'(rr_ptr_q) + off) % NUM_REQ);
         if (!pick_valid && req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign pick_pub = public_keys[{pick_idx, 3'b000} +: 8];
   assign pick_in  = input_keys[{pick_idx, 3'b000} +: 8];

   always_ff @(posedge clock) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (pick_valid) state_d = (pick_pub == REJECT_KEY) ? ST_RESP : ST_HASH;
         ST_HASH:  if (cnt_q == 4'd0) state_d = ST_CHECK;
         ST_CHECK: state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         gnt_idx_q <= '0;
         rr_ptr_q  <= '0;
         pub_key_q <= '0;
         in_key_q  <= '0;
         cnt_q     <= '0;
         result_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (pick_valid) begin
               gnt_idx_q <= pick_idx;
               pub_key_q <= pick_pub;
               in_key_q  <= pick_in;
               cnt_q     <= 4'(HASH_CYCLES - 1);
               result_q  <= 1'b0;
            end
            ST_HASH:  if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            ST_CHECK: result_q <= (hash_val == pub_key_q);
            ST_RESP:  rr_ptr_q <= (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      grant   = '0;
      done    = '0;
      correct = 1'b0;
      busy    = 1'b0;
      if (state_q != ST_IDLE) begin
         busy             = 1'b1;
         grant[gnt_idx_q] = 1'b1;
      end
      if (state_q == ST_RESP) begin
         done[gnt_idx_q] = 1'b1;
         correct         = result_q;
      end
   end

   // Engine runs only through HASH and CHECK; the IDLE cycle that grants
   // keeps it in reset so every operation starts from a clean state.
   assign hash_rst_n = reset_n && ((state_q == ST_HASH) || (state_q == ST_CHECK));

   pearson_hash8 #(
      .ROUNDS (HASH_CYCLES)
   ) u_hash (
      .clock        (clock),
      .reset_n      (hash_rst_n),
      .key          (in_key_q),
      .random_table (random_table),
      .hash         (hash_val)
   );

endmodule

// File: tb/tb_verify_arbiter.sv
module tb_verify_arbiter;
   import verify_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int HC = 8;

   logic           clock = 1'b0;
   logic           reset_n;
   logic [N-1:0]   req;
   logic [8*N-1:0] public_keys, input_keys;
   logic [257:0]   random_table;
   logic [N-1:0]   grant, done;
   logic           correct, busy;

   always #5 clock = ~clock;

   verify_arbiter #(.NUM_REQ(N), .HASH_CYCLES(HC)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req          (req),
      .public_keys  (public_keys),
      .input_keys   (input_keys),
      .random_table (random_table),
      .grant        (grant),
      .done         (done),
      .correct      (correct),
      .busy         (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int lat;
   bit auto_drop = 1'b1;
   int done_log[$];

   // Transaction-level reference: who is being served and how many
   // cycles remain until its done pulse.
   bit m_active = 1'b0;
   int m_who    = 0;
   int m_left   = 0;
   int m_ptr    = 0;
   bit m_correct = 1'b0;

   function automatic logic [7:0] ref_hash(logic [7:0] key, logic [257:0] tbl);
      logic [7:0] h = 8'h00;
      for (int r = 0; r < HC; r++) begin
         int base = int'(h ^ key);
         h = {h[4:0], tbl[base + 2], tbl[base + 1], tbl[base]};
      end
      return h;
   endfunction

   function automatic logic [7:0] good_key();
      logic [7:0] k = 8'h01;
      for (int t = 0; t < 200; t++) begin
         k = 8'($urandom);
         if (ref_hash(k, random_table) != 8'h00) break;
      end
      return k;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_key(int i, logic [7:0] in_k, logic [7:0] pub_k);
      input_keys[8*i +: 8]  = in_k;
      public_keys[8*i +: 8] = pub_k;
   endtask

   task automatic model_edge();
      logic [7:0] pub;
      bit found;
      if (!reset_n) begin
         m_active = 1'b0;
         m_ptr    = 0;
      end else if (m_active) begin
         if (m_left == 0) begin
            m_active = 1'b0;
            m_ptr    = (m_who + 1) % N;
         end else begin
            m_left--;
         end
      end else if (req != '0) begin
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            if (!found && req[(m_ptr + k) % N]) begin
               found = 1'b1;
               m_who = (m_ptr + k) % N;
            end
         end
         pub       = public_keys[8*m_who +: 8];
         m_correct = (pub != 8'h00) && (ref_hash(input_keys[8*m_who +: 8], random_table) == pub);
         m_left    = (pub == 8'h00) ? 0 : HC + 1;
         m_active  = 1'b1;
      end
   endtask

   task automatic step();
      logic [N-1:0] eg, ed;
      @(posedge clock);
      model_edge();
      #1;
      eg = '0;
      ed = '0;
      if (m_active) eg[m_who] = 1'b1;
      if (m_active && m_left == 0) ed[m_who] = 1'b1;
      chk("grant", grant, eg);
      chk("done", done, ed);
      chk("correct", correct, (m_active && m_left == 0) ? m_correct : 1'b0);
      chk("busy", busy, m_active);
      chk("grant_onehot0", $onehot0(grant), 1);
      for (int i = 0; i < N; i++) if (done[i] === 1'b1) done_log.push_back(i);
      if (auto_drop) for (int i = 0; i < N; i++) if (ed[i]) req[i] = 1'b0;
   endtask

   task automatic wait_done(int idx, int budget, output int l);
      int s = 0;
      l = -1;
      while (l < 0 && s < budget) begin
         step();
         s++;
         if (done[idx] === 1'b1) l = s;
      end
   endtask

   initial begin
      logic [7:0] k, h, p;
      int exp_order[5] = '{0, 1, 2, 3, 0};

      reset_n = 1'b0;
      req     = '0;
      for (int b = 0; b < 258; b++) random_table[b] = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) set_key(i, 8'($urandom), 8'($urandom));
      repeat (3) step();
      reset_n = 1'b1;
      step();

      // Matching key on requester 0
      k = good_key();
      set_key(0, k, ref_hash(k, random_table));
      req[0] = 1'b1;
      wait_done(0, 20, lat);
      chk("t029_latency", lat, 10);
      chk("t029_correct", correct, 1);
      repeat (2) step();

      // Wrong key on requester 2
      k = 8'($urandom);
      h = ref_hash(k, random_table);
      p = h ^ 8'h5A;
      if (p == 8'h00) p = h ^ 8'h33;
      set_key(2, k, p);
      req[2] = 1'b1;
      wait_done(2, 20, lat);
      chk("t030_latency", lat, 10);
      chk("t030_correct", correct, 0);
      step();
      chk("t030_busy_after", busy, 0);

      // All four requesting from pointer 0
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         k = good_key();
         set_key(i, k, ref_hash(k, random_table));
      end
      auto_drop = 1'b0;
      done_log.delete();
      req = '1;
      for (int s = 0; s < 80 && done_log.size() < 5; s++) step();
      req = '0;
      chk("t031_done_count", done_log.size(), 5);
      for (int j = 0; j < 5; j++)
         chk("t031_order", (j < done_log.size()) ? done_log[j] : -1, exp_order[j]);
      auto_drop = 1'b1;
      repeat (12) step();

      // Rejected zero key on requester 1
      set_key(1, 8'($urandom), 8'h00);
      req[1] = 1'b1;
      step();
      chk("t032_done", done, 4'b0010);
      chk("t032_correct", correct, 0);
      chk("t032_hash_rst", dut.hash_rst_n, 0);
      step();
      chk("t032_hash_rst_after", dut.hash_rst_n, 0);
      step();

      // Reset during the 5th HASH cycle
      k = good_key();
      set_key(3, k, ref_hash(k, random_table));
      req[3] = 1'b1;
      repeat (5) step();
      reset_n = 1'b0;
      step();
      chk("t033_outputs_zero", {grant, done, correct, busy}, 0);
      reset_n = 1'b1;
      wait_done(3, 20, lat);
      chk("t033_latency", lat, 10);
      chk("t033_correct", correct, 1);
      repeat (2) step();

      // Input key changed after grant
      k = good_key();
      set_key(0, k, ref_hash(k, random_table));
      req[0] = 1'b1;
      step();
      input_keys[7:0] = k ^ 8'hFF;
      wait_done(0, 20, lat);
      chk("t034_latency", lat, 9);
      chk("t034_correct", correct, 1);
      repeat (2) step();

      // Randomised traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 3) == 0) begin
               k = 8'($urandom);
               case ($urandom_range(0, 3))
                  0:       set_key(i, k, 8'h00);
                  1:       set_key(i, k, ref_hash(k, random_table));
                  default: set_key(i, k, 8'($urandom));
               endcase
               req[i] = 1'b1;
            end
         end
         if ($urandom_range(0, 9) == 0)
            input_keys[8*$urandom_range(0, N-1) +: 8] = 8'($urandom);
         if (m_active && $urandom_range(0, 15) == 0) req[m_who] = 1'b0;
         reset_n = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
         step();
      end
      reset_n = 1'b1;
      repeat (15) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
